p2s_serializer: RTL and testbench

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides. It accepts a DATA_W-bit word and emits it one bit per accepted beat, LSB-first or MSB-first, with start/end markers. Back-pressure from the serial consumer stalls the output, and back-to-back words stream with no idle cycle. It sits between a word-oriented producer and a bit-serial link or encoder.

---
 rtl/p2s_pkg.sv | 19 +
 rtl/p2s_shifter.sv | 55 +++++
 rtl/p2s_serializer.sv | 134 +++++++++++++
 tb/tb_p2s_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package p2s_pkg;

   // Two-state control: nothing loaded, or a word held and being shifted out.
   typedef enum logic {
      P2S_IDLE  = 1'b0,
      P2S_SHIFT = 1'b1
   } p2s_state_t;

   // Width of the bit index for a DATA_W-bit word. Indexes 0..DATA_W-1, so
   // $clog2 is enough; clamp at one bit so a degenerate width still elaborates.
   function automatic int p2s_cnt_width(input int data_w);
      if (data_w < 2) begin
         return 1;
      end
      return $clog2(data_w);
   endfunction

endpackage : p2s_pkg

// File: rtl/p2s_shifter.sv
// DATA_W-bit load/shift register. The output bit is the end that is sent
// first: bit 0 for LSB-first, bit DATA_W-1 for MSB-first. Each shift moves
// the next bit into that position and fills the far end with zero.
module p2s_shifter
   import p2s_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   output logic              out_bit
);

   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_d;
   logic [DATA_W-1:0] shifted;

   // Direction of travel and output tap depend only on the bit order.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign shifted = {shreg_q[DATA_W-2:0], 1'b0};
         assign out_bit = shreg_q[DATA_W-1];
      end else begin : g_lsb_first
         assign shifted = {1'b0, shreg_q[DATA_W-1:1]};
         assign out_bit = shreg_q[0];
      end
   endgenerate

   // Next register value: a load wins (back-to-back words), then clear, then shift.
   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = load_data;
      end else if (clear) begin
         shreg_d = '0;
      end else if (shift) begin
         shreg_d = shifted;
      end
   end

   // Register update; reset empties the register so the output bit reads 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

endmodule : p2s_shifter

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides. A word is
// emitted one bit per accepted beat with start/end markers; a new word may be
// loaded on the beat that carries the previous word's last bit, so words
// stream with no idle cycle. Serial-side outputs are registered; only
// in_ready combines ser_ready so the back-to-back reload can happen.
module p2s_serializer
   import p2s_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_data,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_start,
   output logic              ser_end,
   output logic              busy
);

   localparam int               CNT_W    = p2s_cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   p2s_state_t       state_q;
   p2s_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             ser_valid_q;
   logic             ser_valid_d;
   logic             ser_start_q;
   logic             ser_start_d;
   logic             ser_end_q;
   logic             ser_end_d;

   logic             beat;
   logic             accept;
   logic             in_ready_int;
   logic             sh_load;
   logic             sh_shift;
   logic             sh_clear;
   logic             sh_bit;

   // Handshake decode, next state, bit index and shifter controls.
   always_comb begin
      beat         = ser_valid_q & ser_ready;
      in_ready_int = (state_q == P2S_IDLE) | (beat & ser_end_q);
      accept       = in_valid & in_ready_int;

      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_clear = 1'b0;

      case (state_q)
         P2S_IDLE: begin
            if (accept) begin
               state_d = P2S_SHIFT;
               cnt_d   = '0;
               sh_load = 1'b1;
            end
         end
         P2S_SHIFT: begin
            if (beat) begin
               if (cnt_q != CNT_LAST) begin
                  cnt_d    = cnt_q + CNT_W'(1);
                  sh_shift = 1'b1;
               end else if (accept) begin
                  // Last bit leaves and the next word enters on the same edge.
                  cnt_d   = '0;
                  sh_load = 1'b1;
               end else begin
                  state_d  = P2S_IDLE;
                  cnt_d    = '0;
                  sh_clear = 1'b1;
               end
            end
         end
         default: begin
            state_d  = P2S_IDLE;
            cnt_d    = '0;
            sh_clear = 1'b1;
         end
      endcase

      // Markers follow the next state so they stay glitch-free flops; with no
      // beat the state and index hold, so the markers hold as well.
      ser_valid_d = (state_d == P2S_SHIFT);
      ser_start_d = ser_valid_d & (cnt_d == '0);
      ser_end_d   = ser_valid_d & (cnt_d == CNT_LAST);
   end

   // Control state, bit index and registered serial-side flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= P2S_IDLE;
         cnt_q       <= '0;
         ser_valid_q <= 1'b0;
         ser_start_q <= 1'b0;
         ser_end_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ser_valid_q <= ser_valid_d;
         ser_start_q <= ser_start_d;
         ser_end_q   <= ser_end_d;
      end
   end

   p2s_shifter #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .shift     (sh_shift),
      .clear     (sh_clear),
      .load_data (in_data),
      .out_bit   (sh_bit)
   );

   assign in_ready  = in_ready_int;
   assign ser_data  = sh_bit;
   assign ser_valid = ser_valid_q;
   assign ser_start = ser_start_q;
   assign ser_end   = ser_end_q;
   assign busy      = ser_valid_q;

endmodule : p2s_serializer

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three instances (8-bit LSB-first, 8-bit
// MSB-first, 5-bit LSB-first) compared every cycle against a queue model of
// the bits each accepted word must produce.
module tb_p2s_serializer;

   localparam int N_DUT = 3;

   typedef struct packed {
      logic d;
      logic s;
      logic e;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic [7:0] in_data_s   [N_DUT];
   logic       in_valid_s  [N_DUT];
   logic       in_ready_s  [N_DUT];
   logic       ser_data_s  [N_DUT];
   logic       ser_valid_s [N_DUT];
   logic       ser_ready_s [N_DUT];
   logic       ser_start_s [N_DUT];
   logic       ser_end_s   [N_DUT];
   logic       busy_s      [N_DUT];

   int width_c [N_DUT] = '{8, 8, 5};
   int msb_c   [N_DUT] = '{0, 1, 0};

   beat_t      exp_q  [N_DUT][$];
   logic [7:0] word_q [N_DUT][$];
   int         stall_left [N_DUT];

   int n_tests = 0;
   int n_fail  = 0;

   p2s_serializer #(.DATA_W(8), .MSB_FIRST(0)) u_lsb8 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .ser_data(ser_data_s[0]), .ser_valid(ser_valid_s[0]), .ser_ready(ser_ready_s[0]),
      .ser_start(ser_start_s[0]), .ser_end(ser_end_s[0]), .busy(busy_s[0])
   );

   p2s_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_msb8 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .ser_data(ser_data_s[1]), .ser_valid(ser_valid_s[1]), .ser_ready(ser_ready_s[1]),
      .ser_start(ser_start_s[1]), .ser_end(ser_end_s[1]), .busy(busy_s[1])
   );

   p2s_serializer #(.DATA_W(5), .MSB_FIRST(0)) u_lsb5 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data_s[2][4:0]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .ser_data(ser_data_s[2]), .ser_valid(ser_valid_s[2]), .ser_ready(ser_ready_s[2]),
      .ser_start(ser_start_s[2]), .ser_end(ser_end_s[2]), .busy(busy_s[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected serial stream of one word: bits in send order, first marked start, last marked end.
   task automatic push_word(input int i, input logic [7:0] w);
      int    w_n;
      int    idx;
      beat_t b;
      w_n = width_c[i];
      for (int k = 0; k < w_n; k++) begin
         idx = (msb_c[i] != 0) ? (w_n - 1 - k) : k;
         b.d = w[idx];
         b.s = (k == 0);
         b.e = (k == w_n - 1);
         exp_q[i].push_back(b);
      end
   endtask

   // One clock cycle: drive at negedge, check settled outputs, advance the model.
   task automatic step(input int v_pct, input int r_pct);
      logic  exp_rdy;
      beat_t f;
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         if (stall_left[i] > 0) begin
            ser_ready_s[i] = 1'b0;
            stall_left[i]--;
         end else begin
            ser_ready_s[i] = ($urandom_range(99) < r_pct);
         end
         if (word_q[i].size() > 0 && $urandom_range(99) < v_pct) begin
            in_valid_s[i] = 1'b1;
            in_data_s[i]  = word_q[i][0];
         end else begin
            in_valid_s[i] = 1'b0;
            in_data_s[i]  = 8'($urandom());
         end
      end
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         exp_rdy = (exp_q[i].size() == 0) || (ser_ready_s[i] && exp_q[i].size() == 1);
         check($sformatf("in_ready[%0d]", i), 32'(in_ready_s[i]), 32'(exp_rdy));
         check($sformatf("ser_valid[%0d]", i), 32'(ser_valid_s[i]), 32'(exp_q[i].size() > 0));
         check($sformatf("busy[%0d]", i), 32'(busy_s[i]), 32'(exp_q[i].size() > 0));
         if (exp_q[i].size() > 0) begin
            f = exp_q[i][0];
         end else begin
            f = '0;
         end
         check($sformatf("ser_data[%0d]", i), 32'(ser_data_s[i]), 32'(f.d));
         check($sformatf("ser_start[%0d]", i), 32'(ser_start_s[i]), 32'(f.s));
         check($sformatf("ser_end[%0d]", i), 32'(ser_end_s[i]), 32'(f.e));
         if (exp_q[i].size() > 0 && ser_ready_s[i]) begin
            void'(exp_q[i].pop_front());
         end
         if (in_valid_s[i] && exp_rdy) begin
            push_word(i, word_q[i].pop_front());
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("rst_in_ready[%0d]", i), 32'(in_ready_s[i]), 32'd1);
         check($sformatf("rst_ser_valid[%0d]", i), 32'(ser_valid_s[i]), 32'd0);
         check($sformatf("rst_ser_data[%0d]", i), 32'(ser_data_s[i]), 32'd0);
         check($sformatf("rst_ser_start[%0d]", i), 32'(ser_start_s[i]), 32'd0);
         check($sformatf("rst_ser_end[%0d]", i), 32'(ser_end_s[i]), 32'd0);
         check($sformatf("rst_busy[%0d]", i), 32'(busy_s[i]), 32'd0);
      end
   endtask

   // Assert reset at a negedge, hold for a few edges, release half a cycle before the next edge.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N_DUT; i++) begin
         in_valid_s[i]  = 1'b0;
         ser_ready_s[i] = 1'b0;
      end
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs();
      for (int i = 0; i < N_DUT; i++) begin
         exp_q[i].delete();
      end
      rst_n = 1'b1;
   endtask

   function automatic bit all_idle();
      for (int i = 0; i < N_DUT; i++) begin
         if (exp_q[i].size() != 0 || word_q[i].size() != 0) begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic run_until_idle(input string tag, input int max_cyc, input int v_pct, input int r_pct);
      for (int c = 0; c < max_cyc && !all_idle(); c++) begin
         step(v_pct, r_pct);
      end
      check({tag, "_drained"}, 32'(all_idle()), 32'd1);
   endtask

   initial begin
      bit st2;
      bit st7;
      for (int i = 0; i < N_DUT; i++) begin
         in_data_s[i]   = '0;
         in_valid_s[i]  = 1'b0;
         ser_ready_s[i] = 1'b0;
         stall_left[i]  = 0;
      end

      apply_reset();

      // Basic and MSB-first with 8'hA5, odd width with 5'b10110.
      word_q[0].push_back(8'hA5);
      word_q[1].push_back(8'hA5);
      word_q[2].push_back(8'h16);
      run_until_idle("basic", 40, 100, 100);
      step(100, 100);

      // MSB-first recheck with 8'h01: seven zeros then a one with the end marker.
      word_q[1].push_back(8'h01);
      word_q[2].push_back(8'h1F);
      run_until_idle("msb01", 40, 100, 100);

      // Back-pressure on 8'hC3: three stalled cycles at bit index 2 and at index 7.
      word_q[0].push_back(8'hC3);
      st2 = 1'b0;
      st7 = 1'b0;
      for (int c = 0; c < 60 && !all_idle(); c++) begin
         if (exp_q[0].size() > 0) begin
            if (8 - exp_q[0].size() == 2 && !st2) begin
               stall_left[0] = 3;
               st2 = 1'b1;
            end
            if (8 - exp_q[0].size() == 7 && !st7) begin
               stall_left[0] = 3;
               st7 = 1'b1;
            end
         end
         step(100, 100);
      end
      check("bp_stalls_seen", 32'({st2, st7}), 32'd3);
      check("bp_drained", 32'(all_idle()), 32'd1);

      // Streaming: three words back to back with both sides always willing.
      word_q[0].push_back(8'hFF);
      word_q[0].push_back(8'h00);
      word_q[0].push_back(8'h3C);
      word_q[1].push_back(8'h81);
      word_q[1].push_back(8'h7E);
      word_q[2].push_back(8'h0A);
      word_q[2].push_back(8'h15);
      run_until_idle("stream", 60, 100, 100);

      // Reset after the third beat of 8'h5A, then 8'h0F must serialize cleanly.
      word_q[0].push_back(8'h5A);
      for (int c = 0; c < 40 && exp_q[0].size() != 5; c++) begin
         step(100, 100);
      end
      check("mid_reset_pos", 32'(exp_q[0].size()), 32'd5);
      apply_reset();
      word_q[0].push_back(8'h0F);
      run_until_idle("after_reset", 40, 100, 100);

      // Randomized words with random producer gaps and consumer stalls.
      for (int i = 0; i < N_DUT; i++) begin
         for (int k = 0; k < 100; k++) begin
            word_q[i].push_back(8'($urandom()));
         end
      end
      run_until_idle("random", 6000, 70, 60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule : tb_p2s_serializer
